obstacle_tracker: RTL and testbench



---
 rtl/obstacle_tracker.sv | 248 ++++++++++++++++++++++++
 tb/tb_obstacle_tracker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_tracker.sv
// -----------------------------------------------------------------------------
// obstacle_tracker
//   Play-field engine between the frame-tick/input conditioning logic and the
//   game FSM. Scrolls obstacles one column left per frame tick, spawns new
//   obstacles at the right edge at a fixed tick interval into the lowest free
//   slot (lane chosen by an 8-bit LFSR), moves the player between four lanes,
//   counts cleared obstacles and reports win/dead levels.
//
// Optional feature macro: OBSTACLE_TRACKER_LIVES_EN
//   Defined   -> adds livesLeft; the player survives collisions until the
//                last life is used.
//   Undefined -> first collision ends the game.
//
// Ports
//   clk         system clock
//   reset       synchronous active-high reset
//   run         play-state enable from the top level
//   frameTick   one-cycle pulse per frame
//   moveUp      one-cycle pulse, lane - 1 (saturating at 0)
//   moveDown    one-cycle pulse, lane + 1 (saturating at 3)
//   win         level, game won
//   dead        level, game lost
//   playerLane  current player lane 0..3
//   score       cleared-obstacle count (saturating at 255)
//   obsValid    per-slot occupied flags
//   obsX        per-slot column, slot i at [i*XW +: XW]
//   obsLane     per-slot lane, slot i at [i*2 +: 2]
//   livesLeft   remaining lives (only with OBSTACLE_TRACKER_LIVES_EN)
// -----------------------------------------------------------------------------
module obstacle_tracker #(
    parameter int NUM_OBS   = 4,
    parameter int SCREEN_W  = 64,
    parameter int PLAYER_X  = 4,
    parameter int SPAWN_GAP = 16,
    parameter int WIN_SCORE = 20,
    localparam int XW       = $clog2(SCREEN_W)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    frameTick,
    input  logic                    moveUp,
    input  logic                    moveDown,
    output logic                    win,
    output logic                    dead,
    output logic [1:0]              playerLane,
    output logic [7:0]              score,
    output logic [NUM_OBS-1:0]      obsValid,
    output logic [NUM_OBS*XW-1:0]   obsX,
    output logic [NUM_OBS*2-1:0]    obsLane
`ifdef OBSTACLE_TRACKER_LIVES_EN
    ,
    output logic [1:0]              livesLeft
`endif
);

    localparam int CW = $clog2(SPAWN_GAP);
    localparam int IW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;

    localparam logic [CW-1:0] GAP_LAST  = CW'(SPAWN_GAP - 1);
    localparam logic [XW-1:0] X_SPAWN   = XW'(SCREEN_W - 1);
    localparam logic [XW-1:0] X_PLAYER  = XW'(PLAYER_X);
    localparam logic [7:0]    WIN_LIMIT = 8'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE, PLAY, WON, LOST} state_e;

    state_e                     state_q, state_d;
    logic [1:0]                 lane_q, lane_d;
    logic [7:0]                 score_q, score_d;
    logic [NUM_OBS-1:0]         valid_q, valid_d;
    logic [NUM_OBS-1:0][XW-1:0] x_q, x_d;
    logic [NUM_OBS-1:0][1:0]    olane_q, olane_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [7:0]                 lfsr_q, lfsr_d;
`ifdef OBSTACLE_TRACKER_LIVES_EN
    logic [1:0]                 lives_q, lives_d;
`endif

    // Collision is evaluated on registered state only, so the overlap is
    // visible on the outputs one cycle before the state change it causes.
    logic [NUM_OBS-1:0] hit;
    logic               collision;
    logic               has_free;
    logic [IW-1:0]      free_idx;
    logic [3:0]         n_clear;
    logic [8:0]         score_sum;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        hit      = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            hit[i] = valid_q[i] && (x_q[i] == X_PLAYER) && (olane_q[i] == lane_q);
        end
        // Scan downward so the lowest free index is the last one written.
        for (int i = NUM_OBS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
        collision = |hit;
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        score_d   = score_q;
        valid_d   = valid_q;
        x_d       = x_q;
        olane_d   = olane_q;
        cnt_d     = cnt_q;
        n_clear   = '0;
        score_sum = '0;
`ifdef OBSTACLE_TRACKER_LIVES_EN
        lives_d   = lives_q;
`endif
        // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; free-running in every state.
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = PLAY;
                    lane_d  = 2'd1;
                    score_d = '0;
                    valid_d = '0;
                    cnt_d   = '0;
`ifdef OBSTACLE_TRACKER_LIVES_EN
                    lives_d = 2'd3;
`endif
                end
            end

            PLAY: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (collision) begin
                    // A collision cycle only resolves the hit; scrolling,
                    // spawning and moves resume on the following cycle.
`ifdef OBSTACLE_TRACKER_LIVES_EN
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        valid_d = valid_q & ~hit;
                    end else begin
                        lives_d = 2'd0;
                        state_d = LOST;
                    end
`else
                    state_d = LOST;
`endif
                end else begin
                    if (score_q >= WIN_LIMIT) begin
                        state_d = WON;
                    end

                    if (moveUp && !moveDown && lane_q != 2'd0) begin
                        lane_d = lane_q - 2'd1;
                    end else if (moveDown && !moveUp && lane_q != 2'd3) begin
                        lane_d = lane_q + 2'd1;
                    end

                    if (frameTick) begin
                        for (int i = 0; i < NUM_OBS; i++) begin
                            if (valid_q[i]) begin
                                if (x_q[i] == '0) begin
                                    valid_d[i] = 1'b0;
                                    n_clear    = n_clear + 4'd1;
                                end else begin
                                    x_d[i] = x_q[i] - XW'(1);
                                end
                            end
                        end
                        score_sum = {1'b0, score_q} + {5'd0, n_clear};
                        score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];

                        // The spawn target is chosen from pre-tick validity,
                        // so a slot clearing on this tick cannot be reused yet.
                        if (cnt_q == GAP_LAST) begin
                            cnt_d = '0;
                            if (has_free) begin
                                valid_d[free_idx] = 1'b1;
                                x_d[free_idx]     = X_SPAWN;
                                olane_d[free_idx] = lfsr_q[1:0];
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end

            WON, LOST: begin
                if (!run) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the slot arrays are plain flops and are reset along with the
        // rest of the state so obsX/obsLane never show stale or unknown data.
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= 2'd1;
            score_q <= '0;
            valid_q <= '0;
            x_q     <= '0;
            olane_q <= '0;
            cnt_q   <= '0;
            lfsr_q  <= 8'hA5;
`ifdef OBSTACLE_TRACKER_LIVES_EN
            lives_q <= 2'd3;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q <= state_d;
            lane_q  <= lane_d;
            score_q <= score_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            olane_q <= olane_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
`ifdef OBSTACLE_TRACKER_LIVES_EN
            lives_q <= lives_d;
`endif
        end
    end

    assign win        = (state_q == WON);
    assign dead       = (state_q == LOST);
    assign playerLane = lane_q;
    assign score      = score_q;
    assign obsValid   = valid_q;
    assign obsX       = x_q;
    assign obsLane    = olane_q;
`ifdef OBSTACLE_TRACKER_LIVES_EN
    assign livesLeft  = lives_q;
`endif

endmodule

// File: tb/tb_obstacle_tracker.sv
// -----------------------------------------------------------------------------
// tb_obstacle_tracker
//   Directed bench for obstacle_tracker. Three instances share all inputs:
//     dut   - default parameters (lanes, spawn order, clearing, collision)
//     dut_w - SCREEN_W=8, SPAWN_GAP=2, WIN_SCORE=2 (win timing)
//     dut_c - SCREEN_W=8, SPAWN_GAP=5, WIN_SCORE=2 (collision beats win)
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge after each rising edge. Spawn lanes come from a reference LFSR.
// -----------------------------------------------------------------------------
module tb_obstacle_tracker;

    logic clk = 1'b0;
    logic reset, run, frameTick, moveUp, moveDown;

    always #5 clk = ~clk;

    logic        win, dead;
    logic [1:0]  lane;
    logic [7:0]  score;
    logic [3:0]  valid;
    logic [23:0] ox;
    logic [7:0]  olane;

    logic        w_win, w_dead;
    logic [1:0]  w_lane;
    logic [7:0]  w_score;
    logic [3:0]  w_valid;
    logic [11:0] w_ox;
    logic [7:0]  w_olane;

    logic        c_win, c_dead;
    logic [1:0]  c_lane;
    logic [7:0]  c_score;
    logic [3:0]  c_valid;
    logic [11:0] c_ox;
    logic [7:0]  c_olane;

`ifdef OBSTACLE_TRACKER_LIVES_EN
    logic [1:0]  lives, w_lives, c_lives;
`endif

    obstacle_tracker dut (
        .clk(clk), .reset(reset), .run(run), .frameTick(frameTick),
        .moveUp(moveUp), .moveDown(moveDown), .win(win), .dead(dead),
        .playerLane(lane), .score(score), .obsValid(valid), .obsX(ox),
        .obsLane(olane)
`ifdef OBSTACLE_TRACKER_LIVES_EN
        , .livesLeft(lives)
`endif
    );

    obstacle_tracker #(.SCREEN_W(8), .SPAWN_GAP(2), .WIN_SCORE(2)) dut_w (
        .clk(clk), .reset(reset), .run(run), .frameTick(frameTick),
        .moveUp(moveUp), .moveDown(moveDown), .win(w_win), .dead(w_dead),
        .playerLane(w_lane), .score(w_score), .obsValid(w_valid), .obsX(w_ox),
        .obsLane(w_olane)
`ifdef OBSTACLE_TRACKER_LIVES_EN
        , .livesLeft(w_lives)
`endif
    );

    obstacle_tracker #(.SCREEN_W(8), .SPAWN_GAP(5), .WIN_SCORE(2)) dut_c (
        .clk(clk), .reset(reset), .run(run), .frameTick(frameTick),
        .moveUp(moveUp), .moveDown(moveDown), .win(c_win), .dead(c_dead),
        .playerLane(c_lane), .score(c_score), .obsValid(c_valid), .obsX(c_ox),
        .obsLane(c_olane)
`ifdef OBSTACLE_TRACKER_LIVES_EN
        , .livesLeft(c_lives)
`endif
    );

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded 8'hA5 by reset.
    logic [7:0] m_lfsr;
    always @(posedge clk) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [1:0] plane;      // expected player lane
    logic [1:0] last_lane;  // LFSR lane at the most recent tick
    logic [1:0] la, lb, lc, ld;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick1();
        frameTick = 1'b1;
        last_lane = m_lfsr[1:0];
        step();
        frameTick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick1();
            step();
        end
    endtask

    task automatic mv(input logic up, input logic dn);
        moveUp   = up;
        moveDown = dn;
        step();
        moveUp   = 1'b0;
        moveDown = 1'b0;
    endtask

    task automatic go_lane(input logic [1:0] target);
        for (int i = 0; i < 4 && plane != target; i++) begin
            if (target < plane) begin mv(1'b1, 1'b0); plane = plane - 2'd1; end
            else                begin mv(1'b0, 1'b1); plane = plane + 2'd1; end
        end
    endtask

    task automatic restart();
        reset = 1'b1; run = 1'b0;
        step();
        reset = 1'b0; run = 1'b1;
        step();
        plane = 2'd1;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; frameTick = 1'b0; moveUp = 1'b0; moveDown = 1'b0;
        plane = 2'd1; last_lane = '0;
        @(negedge clk);
        repeat (2) step();

        // Reset values
        check("rst_win",   win,   0);
        check("rst_dead",  dead,  0);
        check("rst_lane",  lane,  1);
        check("rst_score", score, 0);
        check("rst_valid", valid, 0);
        check("rst_x",     ox,    0);
        check("rst_olane", olane, 0);
`ifdef OBSTACLE_TRACKER_LIVES_EN
        check("rst_lives", lives, 3);
`endif

        // Enter PLAY
        reset = 1'b0; run = 1'b1;
        step();
        check("play_lane",  lane,  1);
        check("play_score", score, 0);
        check("play_valid", valid, 0);
        check("play_win",   win | dead, 0);

        // Lane bounds
        repeat (3) mv(1'b1, 1'b0);
        check("lane_up_sat", lane, 0);
        repeat (5) mv(1'b0, 1'b1);
        check("lane_dn_sat", lane, 3);
        mv(1'b1, 1'b1);
        check("lane_both", lane, 3);
        plane = 2'd3;

        // Spawn order and clearing
        ticks(16);
        la = last_lane;
        check("spawn0_valid", valid, 4'b0001);
        check("spawn0_x",     ox[5:0], 63);
        check("spawn0_lane",  olane[1:0], la);
        go_lane(la ^ 2'd2);
        ticks(16);
        check("spawn1_valid", valid, 4'b0011);
        check("spawn1_x",     ox[11:6], 63);
        check("spawn1_lane",  olane[3:2], last_lane);
        check("slot0_x_t32",  ox[5:0], 47);
        ticks(16);
        check("spawn2_valid", valid, 4'b0111);
        check("spawn2_lane",  olane[5:4], last_lane);
        ticks(16);
        check("spawn3_valid", valid, 4'b1111);
        check("spawn3_lane",  olane[7:6], last_lane);
        check("slot0_x_t64",  ox[5:0], 15);
        ticks(16);
        check("clear_valid",  valid, 4'b1110);
        check("clear_score",  score, 1);
        check("slot1_x_t80",  ox[11:6], 15);

        // Abort: run=0 suppresses the concurrent move, IDLE ignores moves
        run = 1'b0; moveUp = (plane != 2'd0); moveDown = (plane == 2'd0);
        step();
        moveUp = 1'b0; moveDown = 1'b0;
        check("abort_lane", lane, plane);
        mv(plane != 2'd0, plane == 2'd0);
        check("idle_lane", lane, plane);
        run = 1'b1;
        step();
        check("replay_lane",  lane,  1);
        check("replay_valid", valid, 0);
        check("replay_score", score, 0);
        plane = 2'd1;

        // Reset concurrent with frameTick and moveUp
        ticks(16);
        mv(1'b0, 1'b1);
        reset = 1'b1; frameTick = 1'b1; moveUp = 1'b1;
        step();
        reset = 1'b0; frameTick = 1'b0; moveUp = 1'b0; run = 1'b0;
        check("mrst_lane",  lane,  1);
        check("mrst_valid", valid, 0);
        check("mrst_x",     ox,    0);
        check("mrst_olane", olane, 0);
        check("mrst_flags", {win, dead}, 0);

`ifndef OBSTACLE_TRACKER_LIVES_EN
        // Collision with slot 0 at x=4 after tick 75
        restart();
        ticks(16);
        la = last_lane;
        check("col_spawn", valid, 4'b0001);
        go_lane(la);
        ticks(58);
        tick1();
        check("col_x4",     ox[5:0], 4);
        check("col_dead0",  dead, 0);
        step();
        check("col_dead1",  dead, 1);
        check("col_win0",   win,  0);
        ticks(3);
        mv(plane != 2'd0, plane == 2'd0);
        check("frz_x",      ox[5:0], 4);
        check("frz_lane",   lane, plane);
        check("frz_score",  score, 0);
        check("frz_dead",   dead, 1);
        run = 1'b0;
        step();
        check("lost_idle",  {win, dead}, 0);

        // Collision has priority over win (dut_c)
        restart();
        ticks(5);  la = last_lane;
        go_lane(la ^ 2'd2);
        ticks(5);  lb = last_lane;
        go_lane(lb ^ 2'd2);
        ticks(5);  lc = last_lane;
        check("cw_valid", c_valid, 4'b0011);
        go_lane(lc);
        ticks(2);
        tick1();
        check("cw_score", c_score, 2);
        check("cw_x4",    c_ox[2:0], 4);
        check("cw_pre",   {c_win, c_dead}, 0);
        step();
        check("cw_dead",  c_dead, 1);
        check("cw_win",   c_win,  0);
`else
        // Lives: three collisions
        restart();
        ticks(16); la = last_lane;
        go_lane(la);
        ticks(16); lb = last_lane;
        ticks(16); lc = last_lane;
        ticks(26);
        tick1();
        step();
        check("l1_lives", lives, 2);
        check("l1_valid", valid, 4'b1110);
        check("l1_dead",  dead,  0);
        check("l1_score", score, 0);
        go_lane(lb);
        ticks(15);
        tick1();
        step();
        check("l2_lives", lives, 1);
        check("l2_dead",  dead,  0);
        go_lane(lc);
        ticks(15);
        tick1();
        step();
        check("l3_lives", lives, 0);
        check("l3_dead",  dead,  1);
`endif

        // Win timing (dut_w), player dodging every obstacle
        restart();
        ticks(2); la = last_lane;
        ticks(2); lb = last_lane;
        go_lane(la ^ 2'd2);
        ticks(2); lc = last_lane;
        go_lane(lb ^ 2'd2);
        ticks(2); ld = last_lane;
        check("w_full",   w_valid, 4'b1111);
        go_lane(lc ^ 2'd2);
        ticks(2);
        check("w_drop",   w_valid, 4'b1110);
        check("w_score1", w_score, 1);
        go_lane(ld ^ 2'd2);
        ticks(1);
        tick1();
        check("w_score2", w_score, 2);
        check("w_win0",   w_win,   0);
        step();
        check("w_win1",   w_win,   1);
        check("w_dead0",  w_dead,  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
